// File: rtl/mmcm_ps_ctrl.sv
// mmcm_ps_ctrl: MMCM reset/lock sequencer with paced fine-phase-shift stepping and per-MMCM phase tracking
module mmcm_ps_ctrl #(
   parameter int NUM_MMCM       = 2,
   parameter int RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int PSDONE_TIMEOUT = 255,
   parameter int STEP_W         = 16,
   parameter int ACC_W          = 16,
   localparam int SEL_W         = NUM_MMCM > 1 ? $clog2(NUM_MMCM) : 1
) (
   input  logic                      clk_i,
   input  logic                      reset,
   output logic                      mmcm_rst_o,
   input  logic [NUM_MMCM-1:0]       locked_i,
   input  logic                      relock_i,
   output logic                      ready_o,
   output logic [3:0]                retries_o,
   input  logic                      ps_valid_i,
   output logic                      ps_ready_o,
   input  logic [SEL_W-1:0]          ps_sel_i,
   input  logic [STEP_W-1:0]         ps_steps_i,
   output logic [NUM_MMCM-1:0]       psen_o,
   output logic                      psincdec_o,
   input  logic [NUM_MMCM-1:0]       psdone_i,
   output logic [NUM_MMCM*ACC_W-1:0] phase_o,
   output logic                      err_o
);
   localparam int T_A   = RST_CYCLES > LOCK_TIMEOUT ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int T_MAX = T_A > PSDONE_TIMEOUT ? T_A : PSDONE_TIMEOUT;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam logic [2:0] RST_HOLD  = 3'd0;
   localparam logic [2:0] WAIT_LOCK = 3'd1;
   localparam logic [2:0] IDLE      = 3'd2;
   localparam logic [2:0] PS_PULSE  = 3'd3;
   localparam logic [2:0] PS_WAIT   = 3'd4;
   logic [NUM_MMCM-1:0] sync_a, sync_b;
   logic [2:0]          state, nxt;
   logic [TW-1:0]       timer;
   logic [SEL_W-1:0]    sel_q, psel;
   logic                dir_q, lk, start, step;
   logic [STEP_W-1:0]   rem_q, mag;
   logic [ACC_W-1:0]    delta;
   // request decode and step bookkeeping
   always_comb begin
      lk    = &sync_b;
      start = state == IDLE && lk && !relock_i && ps_valid_i && ps_steps_i != '0;
      step  = state == PS_WAIT && lk && psdone_i[sel_q];
      mag   = ps_steps_i[STEP_W-1] ? -ps_steps_i : ps_steps_i;
      psel  = start ? ps_sel_i : sel_q;
      delta = dir_q ? ACC_W'(1) : '1;
   end
   // next-state: lock loss outranks everything, relock only honoured in IDLE
   always_comb begin
      nxt = state;
      case (state)
         RST_HOLD:  nxt = timer == TW'(RST_CYCLES - 1) ? WAIT_LOCK : RST_HOLD;
         WAIT_LOCK: nxt = lk ? IDLE : timer == TW'(LOCK_TIMEOUT - 1) ? RST_HOLD : WAIT_LOCK;
         IDLE:      nxt = (!lk || relock_i) ? RST_HOLD : start ? PS_PULSE : IDLE;
         PS_PULSE:  nxt = !lk ? RST_HOLD : PS_WAIT;
         PS_WAIT:   nxt = !lk ? RST_HOLD : step ? (rem_q == STEP_W'(1) ? IDLE : PS_PULSE) :
                          timer == TW'(PSDONE_TIMEOUT - 1) ? IDLE : PS_WAIT;
         default:   nxt = RST_HOLD;
      endcase
   end
   // registered state, outputs, accumulators and status
   always_ff @(posedge clk_i) begin
      if (reset) begin
         sync_a     <= '0;
         sync_b     <= '0;
         state      <= RST_HOLD;
         timer      <= '0;
         sel_q      <= '0;
         dir_q      <= 1'b0;
         rem_q      <= '0;
         mmcm_rst_o <= 1'b1;
         ready_o    <= 1'b0;
         ps_ready_o <= 1'b0;
         psen_o     <= '0;
         psincdec_o <= 1'b0;
         phase_o    <= '0;
         err_o      <= 1'b0;
         retries_o  <= '0;
      end else begin
         sync_a     <= locked_i;
         sync_b     <= sync_a;
         state      <= nxt;
         timer      <= (nxt != state || state == IDLE) ? '0 : timer + TW'(1);
         mmcm_rst_o <= nxt == RST_HOLD;
         ready_o    <= nxt == IDLE;
         ps_ready_o <= nxt == IDLE;
         psen_o     <= nxt == PS_PULSE ? NUM_MMCM'(1) << psel : '0;
         psincdec_o <= (nxt == PS_PULSE || nxt == PS_WAIT) ? (start ? ~ps_steps_i[STEP_W-1] : dir_q) : 1'b0;
         sel_q      <= start ? ps_sel_i : sel_q;
         dir_q      <= start ? ~ps_steps_i[STEP_W-1] : dir_q;
         rem_q      <= start ? mag : step ? rem_q - STEP_W'(1) : rem_q;
         if (state == WAIT_LOCK && nxt == RST_HOLD && retries_o != 4'hF)
            retries_o <= retries_o + 4'd1;
         if (state == IDLE && relock_i)
            err_o <= 1'b0;
         else if (state == PS_WAIT && nxt == IDLE && !step)
            err_o <= 1'b1;
         for (int k = 0; k < NUM_MMCM; k++)
            phase_o[k*ACC_W +: ACC_W] <= nxt == RST_HOLD ? '0 :
               (step && sel_q == SEL_W'(k)) ? phase_o[k*ACC_W +: ACC_W] + delta : phase_o[k*ACC_W +: ACC_W];
      end
   end
endmodule
